// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pkg : constants and types shared by the fetch stage                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package riscv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b110_0011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b110_0111;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry synchronous FIFO of {pc, inst}; flush beats push |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_fifo #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [31:0]      push_inst,
  input  logic             pop,
  input  logic             flush,
  output logic [XLEN-1:0]  head_pc,
  output logic [31:0]      head_inst,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  pc_d   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign count     = cnt_q;
  assign head_pc   = pc_q[rd_q];
  assign head_inst = inst_q[rd_q];

  always_comb begin
    do_push = push && !flush && (!full || pop);
    do_pop  = pop && !empty && !flush;
    pc_d    = pc_q;
    inst_d  = inst_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        pc_d[wr_q]   = push_pc;
        inst_d[wr_q] = push_inst;
        wr_d         = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  // The fetch credit scheme must never present a word the FIFO cannot hold.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_unit : PC, credit-limited imem requests, redirect and drop    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSel,
  input  logic [XLEN-1:0] alu_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] PC,
  output logic            inst_valid,
  input  logic            inst_ready
);
  import riscv_pkg::*;

  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, pc_hold_q, pc_hold_d;
  logic [XLEN-1:0]  target, head_pc;
  logic [31:0]      head_inst;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, fifo_count;
  logic [CNT_W:0]   in_use;
  fetch_state_e     state_q, state_d;
  logic             redirect, accept, rsp_take, rsp_drop, push, fifo_empty;

  assign target         = alu_target & ~XLEN'(3);
  assign in_use         = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign redirect       = inst_valid && inst_ready && PCSel;
  assign imem_req_valid = !rst && !redirect && (in_use < CREDIT_MAX);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign rsp_take       = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_drop       = (state_q == FETCH_DRAIN);
  assign push           = rsp_take && !rsp_drop;

  assign inst_valid = !fifo_empty;
  assign Inst       = fifo_empty ? NOP_INST : head_inst;
  assign PC         = fifo_empty ? pc_hold_q : head_pc;

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (rsp_pc_q),
    .push_inst (imem_rsp_data),
    .pop       (inst_ready),
    .flush     (redirect),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    pc_hold_d     = fifo_empty ? pc_hold_q : head_pc;
    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    case ({accept, rsp_take})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (rsp_take && rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);
    // Everything still in flight after a redirect belongs to the old path.
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_cnt_d = outstanding_d;
    end
    state_d = (drop_cnt_d != '0) ? FETCH_DRAIN : FETCH_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      pc_hold_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= FETCH_RUN;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      pc_hold_q     <= pc_hold_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_unit : directed and randomised checks of inst_fetch_unit   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, PCSel = 1'b0, imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] alu_target = '0, imem_rsp_data = '0;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, Inst, PC;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .alu_target(alu_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .Inst(Inst), .PC(PC),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } req_t;
  req_t        pend[$];
  int unsigned cyc = 0;
  logic [31:0] last_due = '0;
  int          checks = 0, failures = 0;
  int unsigned ready_pct = 100, lat_min = 1, lat_max = 1, slow_lat = 1;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  logic        s_req, s_acc, s_iv, s_fire, s_redir;
  logic [31:0] s_addr, s_inst, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  // One clock cycle: memory drives its response, inputs settle, outputs are
  // sampled mid-cycle, then the clock edge is taken.
  task automatic cycle();
    req_t        r;
    int unsigned lat;
    logic [31:0] due;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    s_req   = imem_req_valid;
    s_addr  = imem_req_addr;
    s_acc   = imem_req_valid && imem_req_ready;
    s_iv    = inst_valid;
    s_inst  = Inst;
    s_pc    = PC;
    s_fire  = inst_valid && inst_ready;
    s_redir = s_fire && PCSel;
    if (s_acc) begin
      lat = (imem_req_addr == slow_addr) ? slow_lat : $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      r.addr = imem_req_addr;
      r.due  = due;
      pend.push_back(r);
      last_due = due;
    end
    if (rst) begin
      pend.delete();
      last_due = '0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; inst_ready = 1'b0; PCSel = 1'b0; alu_target = '0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    slow_addr = 32'hFFFF_FFFF; slow_lat = 1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", s_req); end
    checks++; if (s_iv !== 1'b0) begin failures++; $display("FAIL reset_inst_valid: got %b expected 0", s_iv); end
    checks++; if (s_inst !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst: got %h expected 00000013", s_inst); end
    checks++; if (s_pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h expected %h", s_pc, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr, exp_pc;
    int first, n;
    apply_reset();
    inst_ready = 1'b1;
    exp_addr = RESET_PC; exp_pc = RESET_PC; first = -1; n = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (s_iv && first < 0) first = i;
      if (s_acc) begin
        checks++; if (s_addr !== exp_addr) begin failures++; $display("FAIL stream_addr: got %h expected %h", s_addr, exp_addr); end
        exp_addr += 4;
      end
      if (s_fire) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          failures++; $display("FAIL stream_inst: got pc %h inst %h expected pc %h inst %h", s_pc, s_inst, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; n++;
      end
    end
    // Release cycle is cycle 0, so the third cycle after release is index 2.
    checks++; if (first != 2) begin failures++; $display("FAIL stream_first_valid: got %0d expected 2", first); end
    checks++; if (n < 12) begin failures++; $display("FAIL stream_count: got %0d expected at least 12", n); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int acc, n;
    apply_reset();
    inst_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_acc) acc++;
      if (s_iv) begin
        checks++; if (s_pc !== 32'h0 || s_inst !== mem_word(32'h0)) begin
          failures++; $display("FAIL hold_stable: got pc %h inst %h expected pc 00000000 inst %h", s_pc, s_inst, mem_word(32'h0)); end
      end
    end
    checks++; if (acc != 2) begin failures++; $display("FAIL hold_req_count: got %0d expected 2", acc); end
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL hold_req_valid: got %b expected 0", s_req); end
    inst_ready = 1'b1; exp_pc = 32'h0; n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_fire) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          failures++; $display("FAIL drain_order: got pc %h inst %h expected pc %h", s_pc, s_inst, exp_pc); end
        exp_pc += 4; n++;
      end
    end
    checks++; if (n < 6) begin failures++; $display("FAIL drain_count: got %0d expected at least 6", n); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    logic redirected, seen_acc, seen_new;
    apply_reset();
    slow_addr = 32'h0000_000C; slow_lat = 4;
    exp_pc = 32'h0; redirected = 1'b0; seen_acc = 1'b0; seen_new = 1'b0;
    alu_target = 32'h0000_0100;
    for (int i = 0; i < 20; i++) begin
      inst_ready = 1'b1;
      PCSel = inst_valid && (PC == 32'h8);
      cycle();
      if (s_redir) begin
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL redir_no_req: got %b expected 0", s_req); end
      end
      if (s_acc && redirected && !seen_acc) begin
        seen_acc = 1'b1;
        checks++; if (s_addr !== 32'h100) begin failures++; $display("FAIL redir_addr: got %h expected 00000100", s_addr); end
      end
      if (s_fire) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          failures++; $display("FAIL redir_stream: got pc %h expected %h", s_pc, exp_pc); end
        if (redirected) seen_new = 1'b1;
      end
      if (s_redir) begin exp_pc = 32'h100; redirected = 1'b1; end
      else if (s_fire) exp_pc += 4;
    end
    PCSel = 1'b0;
    checks++; if (!(redirected && seen_new)) begin failures++; $display("FAIL redir_delivered: got %b expected 1", redirected && seen_new); end
  endtask

  task automatic redirect_case(input logic [31:0] tgt, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    logic [31:0] got_a[2], got_p[2];
    int na, np;
    logic redirected;
    apply_reset();
    alu_target = tgt; na = 0; np = 0; redirected = 1'b0;
    got_a[0] = 'x; got_a[1] = 'x; got_p[0] = 'x; got_p[1] = 'x;
    for (int i = 0; i < 14; i++) begin
      inst_ready = 1'b1;
      PCSel = inst_valid && (PC == RESET_PC) && !redirected;
      cycle();
      if (redirected && s_acc && na < 2) begin got_a[na] = s_addr; na++; end
      if (redirected && s_fire && np < 2) begin got_p[np] = s_pc; np++; end
      if (s_redir) redirected = 1'b1;
    end
    PCSel = 1'b0;
    checks++; if (got_a[0] !== exp_a0) begin failures++; $display("FAIL target_addr0: got %h expected %h", got_a[0], exp_a0); end
    checks++; if (got_a[1] !== exp_a1) begin failures++; $display("FAIL target_addr1: got %h expected %h", got_a[1], exp_a1); end
    checks++; if (got_p[0] !== exp_a0) begin failures++; $display("FAIL target_pc0: got %h expected %h", got_p[0], exp_a0); end
    checks++; if (got_p[1] !== exp_a1) begin failures++; $display("FAIL target_pc1: got %h expected %h", got_p[1], exp_a1); end
  endtask

  task automatic test_align_wrap();
    redirect_case(32'h0000_0103, 32'h0000_0100, 32'h0000_0104);
    redirect_case(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_addr;
    int n;
    apply_reset();
    ready_pct = 70; lat_min = 1; lat_max = 5;
    exp_pc = RESET_PC; exp_addr = RESET_PC; n = 0;
    for (int i = 0; i < 2000; i++) begin
      inst_ready = ($urandom_range(3) != 0);
      PCSel = inst_valid && inst_ready && ($urandom_range(9) == 0);
      alu_target = $urandom();
      cycle();
      if (s_acc) begin
        checks++; if (s_addr !== exp_addr) begin failures++; $display("FAIL rand_addr: got %h expected %h", s_addr, exp_addr); end
        exp_addr += 4;
      end
      if (s_redir) begin
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL rand_redir_req: got %b expected 0", s_req); end
      end
      if (s_fire) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          failures++; $display("FAIL rand_inst: got pc %h inst %h expected pc %h inst %h", s_pc, s_inst, exp_pc, mem_word(exp_pc)); end
        n++;
      end
      if (s_redir) begin
        exp_pc   = {alu_target[31:2], 2'b00};
        exp_addr = {alu_target[31:2], 2'b00};
      end else if (s_fire) exp_pc += 4;
    end
    PCSel = 1'b0;
    checks++; if (n < 100) begin failures++; $display("FAIL rand_count: got %0d expected at least 100", n); end
  endtask

  task automatic test_reset_drain();
    logic found, seen;
    logic [31:0] exp_pc;
    apply_reset();
    slow_addr = 32'h0000_000C; slow_lat = 4;
    alu_target = 32'h0000_0100; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      inst_ready = 1'b1;
      PCSel = inst_valid && (PC == 32'h8);
      cycle();
      if (s_redir) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL drain_setup: got %b expected 1", found); end
    rst = 1'b1; inst_ready = 1'b0; PCSel = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL drain_rst_req: got %b expected 0", s_req); end
    rst = 1'b0;
    slow_addr = 32'hFFFF_FFFF;
    cycle();
    checks++; if (s_iv !== 1'b0) begin failures++; $display("FAIL drain_rst_valid: got %b expected 0", s_iv); end
    checks++; if (s_inst !== 32'h0000_0013) begin failures++; $display("FAIL drain_rst_inst: got %h expected 00000013", s_inst); end
    checks++; if (s_pc !== RESET_PC) begin failures++; $display("FAIL drain_rst_pc: got %h expected %h", s_pc, RESET_PC); end
    checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      failures++; $display("FAIL drain_rst_fetch: got valid %b addr %h expected valid 1 addr %h", s_req, s_addr, RESET_PC); end
    inst_ready = 1'b1; exp_pc = RESET_PC; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_fire) begin
        checks++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          failures++; $display("FAIL drain_resume: got pc %h expected %h", s_pc, exp_pc); end
        exp_pc += 4; seen = 1'b1;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL drain_resume_any: got 0 expected 1"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align_wrap();
    test_random();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
